// File: rtl/vxc_add_row_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : vxc_add_row_scheduler
//  Description : Runs multi-row "result = second_row op (first_row x constant)"
//                jobs through the 8-lane complex multiply/add datapath.
//                It issues one operand row read per cycle, holds op/constant
//                stable for the whole job, and tracks in-flight rows with a
//                valid pipeline so that result writes come out in order.
//                It pulses done once the last row has been written.
//
//  Ports       : clk             rising-edge clock
//                reset           asynchronous active-low reset
//                start           one-cycle job request (sampled in IDLE only)
//                num_rows        rows in the job (0 is legal)
//                first_base      first operand memory start row
//                second_base     second operand memory start row
//                result_base     result memory start row
//                op_in           0 = add, 1 = subtract
//                constant_in     complex scalar (32-bit re, 32-bit im)
//                rd_en           operand read strobe (both memories)
//                rd_addr_first   first operand memory address
//                rd_addr_second  second operand memory address
//                dp_op           latched op to the datapath
//                dp_constant     latched constant to the datapath
//                wr_en           result write strobe
//                wr_addr         result memory address
//                busy            job in progress
//                done            one-cycle completion pulse
//
//  Revision    : 1.0  initial release
// ============================================================================
module vxc_add_row_scheduler #(
    parameter int ADDR_WIDTH    = 10,
    parameter int ELEMENT_WIDTH = 64,
    parameter int MEM_LATENCY   = 1,
    parameter int DP_LATENCY    = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    num_rows,
    input  logic [ADDR_WIDTH-1:0]    first_base,
    input  logic [ADDR_WIDTH-1:0]    second_base,
    input  logic [ADDR_WIDTH-1:0]    result_base,
    input  logic                     op_in,
    input  logic [ELEMENT_WIDTH-1:0] constant_in,
    output logic                     rd_en,
    output logic [ADDR_WIDTH-1:0]    rd_addr_first,
    output logic [ADDR_WIDTH-1:0]    rd_addr_second,
    output logic                     dp_op,
    output logic [ELEMENT_WIDTH-1:0] dp_constant,
    output logic                     wr_en,
    output logic [ADDR_WIDTH-1:0]    wr_addr,
    output logic                     busy,
    output logic                     done
);

    // Total cycles from a read strobe to the matching result write.
    localparam int                    c_PIPE_DEPTH = MEM_LATENCY + DP_LATENCY;
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ZERO  = '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;

    logic [ADDR_WIDTH-1:0]      r_last_row;       // num_rows - 1 of the current job
    logic                       r_zero_job;       // current job has no rows
    logic [ADDR_WIDTH-1:0]      r_rd_cnt;         // k: row being issued
    logic [ADDR_WIDTH-1:0]      r_wr_cnt;         // j: row being written
    logic [ADDR_WIDTH-1:0]      r_rd_addr_first;
    logic [ADDR_WIDTH-1:0]      r_rd_addr_second;
    logic [ADDR_WIDTH-1:0]      r_wr_addr;
    logic                       r_dp_op;
    logic [ELEMENT_WIDTH-1:0]   r_dp_constant;
    logic [c_PIPE_DEPTH-1:0]    r_vpipe;

    logic                       w_accept;
    logic                       w_rd_en;
    logic                       w_wr_en;
    logic                       w_busy;
    logic                       w_done;
    logic                       w_last_issue;
    logic                       w_last_write;

    // ------------------------------------------------------------------
    // Job acceptance and end-of-phase detection
    // ------------------------------------------------------------------
    assign w_accept     = (r_state == S_IDLE) && start;
    assign w_wr_en      = r_vpipe[c_PIPE_DEPTH-1];
    assign w_last_issue = w_rd_en && (r_rd_cnt == r_last_row);
    assign w_last_write = w_wr_en && (r_wr_cnt == r_last_row);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_state_next = (num_rows == c_ADDR_ZERO) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_rd_en = 1'b1;
                if (r_rd_cnt == r_last_row) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_write) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                // An empty job spends one settling cycle here before the
                // done pulse, so it is visible as busy for two cycles.
                if (!r_zero_job) begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Job descriptor, counters and address generators
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_row       <= '0;
            r_zero_job       <= 1'b0;
            r_rd_cnt         <= '0;
            r_wr_cnt         <= '0;
            r_rd_addr_first  <= '0;
            r_rd_addr_second <= '0;
            r_wr_addr        <= '0;
            r_dp_op          <= 1'b0;
            r_dp_constant    <= '0;
        end else if (w_accept) begin
            r_last_row       <= num_rows - c_ADDR_ONE;
            r_zero_job       <= (num_rows == c_ADDR_ZERO);
            r_rd_cnt         <= '0;
            r_wr_cnt         <= '0;
            r_rd_addr_first  <= first_base;
            r_rd_addr_second <= second_base;
            r_wr_addr        <= result_base;
            r_dp_op          <= op_in;
            r_dp_constant    <= constant_in;
        end else begin
            // Counters stop on the final row so addresses keep the last
            // strobed value once the strobe drops. Wrap is modulo 2^ADDR_WIDTH.
            if (w_rd_en && !w_last_issue) begin
                r_rd_cnt         <= r_rd_cnt + c_ADDR_ONE;
                r_rd_addr_first  <= r_rd_addr_first + c_ADDR_ONE;
                r_rd_addr_second <= r_rd_addr_second + c_ADDR_ONE;
            end
            if (w_wr_en && !w_last_write) begin
                r_wr_cnt  <= r_wr_cnt + c_ADDR_ONE;
                r_wr_addr <= r_wr_addr + c_ADDR_ONE;
            end
            if (r_state == S_FINISH) begin
                r_zero_job <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Valid pipeline: carries each read strobe to its result write
    // ------------------------------------------------------------------
    generate
        if (c_PIPE_DEPTH > 1) begin : g_vpipe_multi
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe <= {r_vpipe[c_PIPE_DEPTH-2:0], w_rd_en};
                end
            end
        end else begin : g_vpipe_single
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe <= w_rd_en;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_en          = w_rd_en;
    assign rd_addr_first  = r_rd_addr_first;
    assign rd_addr_second = r_rd_addr_second;
    assign dp_op          = r_dp_op;
    assign dp_constant    = r_dp_constant;
    assign wr_en          = w_wr_en;
    assign wr_addr        = r_wr_addr;
    assign busy           = w_busy;
    assign done           = w_done;

endmodule
`default_nettype wire
